// File: rtl/throttle_pkg.sv
// throttle_pkg: shared defaults and elaboration-time helpers for the throttle controller.
package throttle_pkg;

   localparam int NUM_LEVELS_DEF    = 6;
   localparam int BASE_DIV_LOG2_DEF = 26;
   localparam int DB_CYCLES_DEF     = 8;

   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         bits++;
      end
      return (bits < 1) ? 1 : bits;
   endfunction

   // Higher level selects a lower counter bit, hence a faster rate.
   function automatic int level_bit(input int base_log2, input int lvl);
      return base_log2 - 1 - lvl;
   endfunction

endpackage

// File: rtl/throttle_debounce.sv
// throttle_debounce: 2-FF synchroniser, stability filter and one-cycle press pulse for one button.
// Define THROTTLE_AUTOREPEAT_EN to add a hold-to-repeat timer that emits extra press pulses.
module throttle_debounce
   import throttle_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF
`ifdef THROTTLE_AUTOREPEAT_EN
   ,
   parameter int REPEAT_LOG2 = BASE_DIV_LOG2_DEF
`endif
)(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic press_o
);

   localparam int            CW       = clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          acc_q, acc_d, acc_dly_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;
   logic          rpt_fire;

   // The run counter restarts whenever the sample agrees with the accepted state.
   always_comb begin
      acc_d = acc_q;
      cnt_d = '0;
      if (sync2_q != acc_q) begin
         if (cnt_q == CNT_LAST) begin
            acc_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

`ifdef THROTTLE_AUTOREPEAT_EN
   localparam int            RW        = REPEAT_LOG2 - 1;
   localparam logic [RW-1:0] HOLD_LAST = {RW{1'b1}};
   localparam logic [RW-1:0] RATE_LAST = RW'((1 << (REPEAT_LOG2 - 2)) - 1);

   logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
   logic          rpt_armed_q, rpt_armed_d;

   // Long initial hold first, then the shorter repeat interval once armed.
   always_comb begin
      rpt_cnt_d   = rpt_cnt_q + 1'b1;
      rpt_armed_d = rpt_armed_q;
      rpt_fire    = 1'b0;
      if (!acc_q) begin
         rpt_cnt_d   = '0;
         rpt_armed_d = 1'b0;
      end else if ((!rpt_armed_q && rpt_cnt_q == HOLD_LAST) ||
                   ( rpt_armed_q && rpt_cnt_q == RATE_LAST)) begin
         rpt_fire    = 1'b1;
         rpt_cnt_d   = '0;
         rpt_armed_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rpt_cnt_q   <= '0;
         rpt_armed_q <= 1'b0;
      end else begin
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_armed_q <= rpt_armed_d;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   assign press_d = (acc_q & ~acc_dly_q) | rpt_fire;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         acc_q     <= 1'b0;
         acc_dly_q <= 1'b0;
         cnt_q     <= '0;
         press_q   <= 1'b0;
      end else begin
         sync1_q   <= btn_i;
         sync2_q   <= sync1_q;
         acc_q     <= acc_d;
         acc_dly_q <= acc_q;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/throttle_ctrl.sv
// throttle_ctrl: button/load driven rate selector producing a 50% slow clock and a one-cycle tick.
// Define THROTTLE_AUTOREPEAT_EN to enable hold-to-repeat on both buttons.
module throttle_ctrl
   import throttle_pkg::*;
#(
   parameter int  NUM_LEVELS    = NUM_LEVELS_DEF,
   parameter int  BASE_DIV_LOG2 = BASE_DIV_LOG2_DEF,
   parameter int  DB_CYCLES     = DB_CYCLES_DEF,
   localparam int LVL_W         = clog2(NUM_LEVELS)
)(
   input  logic             CLK_50,
   input  logic             reset,
   input  logic             pb_freq_up,
   input  logic             pb_freq_dn,
   input  logic             run,
   input  logic             step,
   input  logic             lvl_load,
   input  logic [LVL_W-1:0] lvl_in,
   output logic             slow_clk,
   output logic             tick,
   output logic [LVL_W-1:0] level,
   output logic             at_min,
   output logic             at_max
);

   localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_LEVELS - 1);

   logic [1:0]               btn_raw, btn_ev;
   logic                     up_ev, dn_ev;
   logic [LVL_W-1:0]         level_q, level_d;
   logic                     lvl_chg;
   logic                     at_min_q, at_max_q;
   logic [BASE_DIV_LOG2-1:0] cnt_q, cnt_d;
   logic                     slow_q, slow_d;
   logic                     tick_q, tick_d;
   logic [NUM_LEVELS-1:0]    tap;
   logic                     sel_bit;

   assign btn_raw = {pb_freq_dn, pb_freq_up};

   for (genvar gi = 0; gi < 2; gi++) begin : g_db
      throttle_debounce #(
         .DB_CYCLES   (DB_CYCLES)
`ifdef THROTTLE_AUTOREPEAT_EN
         ,
         .REPEAT_LOG2 (BASE_DIV_LOG2)
`endif
      ) u_db (
         .clk_i   (CLK_50),
         .rst_ni  (reset),
         .btn_i   (btn_raw[gi]),
         .press_o (btn_ev[gi])
      );
   end

   assign up_ev = btn_ev[0];
   assign dn_ev = btn_ev[1];

   // Load outranks buttons; opposing events cancel.
   always_comb begin
      level_d = level_q;
      if (lvl_load) begin
         level_d = (lvl_in > LVL_MAX) ? LVL_MAX : lvl_in;
      end else if (up_ev && !dn_ev && level_q != LVL_MAX) begin
         level_d = level_q + 1'b1;
      end else if (dn_ev && !up_ev && level_q != '0) begin
         level_d = level_q - 1'b1;
      end
   end

   // Saturated requests leave the level untouched and do not restart the phase.
   assign lvl_chg = (level_d != level_q);

   for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_tap
      assign tap[gi] = cnt_q[level_bit(BASE_DIV_LOG2, gi)];
   end

   assign sel_bit = tap[level_q];

   always_comb begin
      cnt_d  = cnt_q;
      slow_d = slow_q;
      tick_d = 1'b0;
      if (lvl_chg) begin
         cnt_d  = '0;
         slow_d = 1'b0;
      end else if (run) begin
         cnt_d  = cnt_q + 1'b1;
         slow_d = sel_bit;
         tick_d = sel_bit & ~slow_q;
      end else begin
         tick_d = step;
      end
   end

   always_ff @(posedge CLK_50) begin
      if (!reset) begin
         level_q  <= '0;
         at_min_q <= 1'b1;
         at_max_q <= 1'b0;
         cnt_q    <= '0;
         slow_q   <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         level_q  <= level_d;
         at_min_q <= (level_d == '0);
         at_max_q <= (level_d == LVL_MAX);
         cnt_q    <= cnt_d;
         slow_q   <= slow_d;
         tick_q   <= tick_d;
      end
   end

   assign slow_clk = slow_q;
   assign tick     = tick_q;
   assign level    = level_q;
   assign at_min   = at_min_q;
   assign at_max   = at_max_q;

endmodule

// File: tb/tb_throttle_ctrl.sv
// tb_throttle_ctrl: directed sequences, a vector table and random traffic against a reference model.
module tb_throttle_ctrl;

   localparam int NL = 4;
   localparam int BD = 6;
   localparam int DB = 4;
   localparam int LW = 2;

   logic          CLK_50 = 1'b0;
   logic          reset, pb_freq_up, pb_freq_dn, run, step, lvl_load;
   logic [LW-1:0] lvl_in;
   logic          slow_clk, tick, at_min, at_max;
   logic [LW-1:0] level;

   int checks = 0;
   int errors = 0;
   int cyc_n = 0;
   int last_tick = 0;
   int tick_gap = 0;

   // Reference model state: raw sample history, accepted-state history, level and run count.
   int hu [DB+2];
   int hd [DB+2];
   int au [3];
   int ad [3];
   int m_level = 0;
   int m_n = 0;
   bit m_slow = 1'b0;
   bit m_tick = 1'b0;

   typedef struct {
      int op;     // 0 up, 1 down, 2 both, 3 load
      int val;
      int lvl;
      int mn;
      int mx;
   } vec_t;
   vec_t tbl [15];

   throttle_ctrl #(
      .NUM_LEVELS    (NL),
      .BASE_DIV_LOG2 (BD),
      .DB_CYCLES     (DB)
   ) dut (
      .CLK_50     (CLK_50),
      .reset      (reset),
      .pb_freq_up (pb_freq_up),
      .pb_freq_dn (pb_freq_dn),
      .run        (run),
      .step       (step),
      .lvl_load   (lvl_load),
      .lvl_in     (lvl_in),
      .slow_clk   (slow_clk),
      .tick       (tick),
      .level      (level),
      .at_min     (at_min),
      .at_max     (at_max)
   );

   always #5 CLK_50 = ~CLK_50;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   // A button is accepted once the last DB synchronised samples all disagree with it.
   task automatic db_update(inout int h [DB+2], inout int a [3], input int raw);
      int flip;
      for (int i = DB + 1; i > 0; i--) h[i] = h[i-1];
      h[0] = raw;
      flip = 1;
      for (int i = 2; i <= DB + 1; i++) if (h[i] == a[0]) flip = 0;
      a[2] = a[1];
      a[1] = a[0];
      if (flip != 0) a[0] = 1 - a[0];
   endtask

   task automatic model_edge();
      int ev_u, ev_d, old, k, ns;
      if (reset !== 1'b1) begin
         for (int i = 0; i < DB + 2; i++) begin hu[i] = 0; hd[i] = 0; end
         for (int i = 0; i < 3; i++) begin au[i] = 0; ad[i] = 0; end
         m_level = 0; m_n = 0; m_slow = 1'b0; m_tick = 1'b0;
         return;
      end
      ev_u = (au[1] == 1 && au[2] == 0) ? 1 : 0;
      ev_d = (ad[1] == 1 && ad[2] == 0) ? 1 : 0;
      db_update(hu, au, (pb_freq_up === 1'b1) ? 1 : 0);
      db_update(hd, ad, (pb_freq_dn === 1'b1) ? 1 : 0);
      old = m_level;
      if (lvl_load === 1'b1) m_level = (int'(lvl_in) > NL - 1) ? NL - 1 : int'(lvl_in);
      else if (ev_u == 1 && ev_d == 0) m_level = (old + 1 > NL - 1) ? NL - 1 : old + 1;
      else if (ev_d == 1 && ev_u == 0) m_level = (old - 1 < 0) ? 0 : old - 1;
      if (m_level != old) begin
         m_n = 0; m_slow = 1'b0; m_tick = 1'b0;
      end else if (run === 1'b1) begin
         k = BD - 1 - old;
         ns = (m_n / (1 << k)) % 2;
         m_tick = (ns == 1 && !m_slow);
         m_slow = (ns == 1);
         m_n++;
      end else begin
         m_tick = (step === 1'b1);
      end
   endtask

   task automatic cyc();
      logic [5:0] act, exp;
      @(posedge CLK_50);
      model_edge();
      #1;
      cyc_n++;
      act = {slow_clk, tick, level, at_min, at_max};
      exp = {m_slow, m_tick, 2'(m_level), (m_level == 0), (m_level == NL - 1)};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL model cyc=%0d got=%b want=%b (slow,tick,level,min,max)", cyc_n, act, exp);
      end
      if (tick === 1'b1) begin
         tick_gap = cyc_n - last_tick;
         last_tick = cyc_n;
      end
   endtask

   task automatic press(input logic up, input logic dn);
      pb_freq_up = up; pb_freq_dn = dn;
      repeat (12) cyc();
      pb_freq_up = 1'b0; pb_freq_dn = 1'b0;
      repeat (10) cyc();
   endtask

   task automatic load(input int v);
      lvl_load = 1'b1; lvl_in = LW'(v);
      cyc();
      lvl_load = 1'b0;
      repeat (3) cyc();
   endtask

   initial begin
      int t1, t2, hi, tk, ch, got, w, hold_u, hold_d;
      logic s0;

      reset = 1'b0; pb_freq_up = 1'b1; pb_freq_dn = 1'b1;
      run = 1'b1; step = 1'b0; lvl_load = 1'b0; lvl_in = '0;

      // Reset with both buttons held.
      repeat (2) cyc();
      check("rst_level", int'(level), 0);
      check("rst_slow", int'(slow_clk), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_at_min", int'(at_min), 1);
      check("rst_at_max", int'(at_max), 0);
      reset = 1'b1; pb_freq_dn = 1'b0;
      repeat (3) cyc();
      pb_freq_up = 1'b0;
      repeat (10) cyc();
      check("no_event_after_reset", int'(level), 0);
      $display("seq reset: level=%0d at_min=%0d", level, at_min);

      // Clean up press: level moves on edge DB+4 exactly.
      pb_freq_up = 1'b1;
      repeat (7) cyc();
      check("up_edge7", int'(level), 0);
      cyc();
      check("up_edge8", int'(level), 1);
      t1 = 0; t2 = 0; hi = 0;
      for (int j = 1; j <= 100; j++) begin
         if (j == 13) pb_freq_up = 1'b0;
         cyc();
         if (tick === 1'b1 && t1 == 0) t1 = j;
         else if (tick === 1'b1 && t2 == 0) t2 = j;
         if (j >= 17 && j <= 48 && slow_clk === 1'b1) hi++;
      end
      check("first_tick_lvl1", t1, 17);
      check("tick_period_lvl1", t2 - t1, 32);
      check("slow_high_cycles", hi, 16);
      check("single_event", int'(level), 1);
      $display("seq press: first_tick=%0d period=%0d high=%0d", t1, t2 - t1, hi);

      // Bouncing input never settles long enough to register.
      for (int c = 0; c < 40; c++) begin
         pb_freq_up = ((c / 2) % 2 == 0);
         cyc();
      end
      pb_freq_up = 1'b0;
      got = 0; w = 0;
      while (got == 0 && w < 40) begin
         cyc(); w++;
         if (tick === 1'b1) got = 1;
      end
      check("bounce_tick_seen", got, 1);
      check("bounce_phase", tick_gap, 32);
      check("bounce_level", int'(level), 1);
      $display("seq bounce: level=%0d tick_gap=%0d", level, tick_gap);

      // Vector table: press/load operations and resulting level flags.
      tbl[0]  = '{1, 0, 0, 1, 0};
      tbl[1]  = '{0, 0, 1, 0, 0};
      tbl[2]  = '{0, 0, 2, 0, 0};
      tbl[3]  = '{0, 0, 3, 0, 1};
      tbl[4]  = '{0, 0, 3, 0, 1};
      tbl[5]  = '{0, 0, 3, 0, 1};
      tbl[6]  = '{2, 0, 3, 0, 1};
      tbl[7]  = '{1, 0, 2, 0, 0};
      tbl[8]  = '{1, 0, 1, 0, 0};
      tbl[9]  = '{1, 0, 0, 1, 0};
      tbl[10] = '{1, 0, 0, 1, 0};
      tbl[11] = '{3, 2, 2, 0, 0};
      tbl[12] = '{3, 0, 0, 1, 0};
      tbl[13] = '{2, 0, 0, 1, 0};
      tbl[14] = '{3, 3, 3, 0, 1};
      for (int i = 0; i < 15; i++) begin
         case (tbl[i].op)
            0:       press(1'b1, 1'b0);
            1:       press(1'b0, 1'b1);
            2:       press(1'b1, 1'b1);
            default: load(tbl[i].val);
         endcase
         check($sformatf("tbl%0d_level", i), int'(level), tbl[i].lvl);
         check($sformatf("tbl%0d_at_min", i), int'(at_min), tbl[i].mn);
         check($sformatf("tbl%0d_at_max", i), int'(at_max), tbl[i].mx);
         $display("tbl[%0d] op=%0d val=%0d -> level=%0d at_min=%0d at_max=%0d",
                  i, tbl[i].op, tbl[i].val, level, at_min, at_max);
      end

      // Pause freezes the rate generator; step gives exactly one tick.
      repeat (20) cyc();
      s0 = slow_clk;
      run = 1'b0; tk = 0; ch = 0;
      for (int j = 0; j < 100; j++) begin
         cyc();
         if (tick === 1'b1) tk++;
         if (slow_clk !== s0) ch++;
      end
      check("pause_ticks", tk, 0);
      check("pause_slow_changes", ch, 0);
      step = 1'b1;
      cyc();
      step = 1'b0;
      check("step_tick", int'(tick), 1);
      cyc();
      check("step_single", int'(tick), 0);
      run = 1'b1; lvl_load = 1'b1; lvl_in = 2'd1;
      cyc();
      lvl_load = 1'b0;
      repeat (2) cyc();
      step = 1'b1;
      cyc();
      step = 1'b0;
      check("step_while_run", int'(tick), 0);
      $display("seq pause: ticks=%0d slow_changes=%0d level=%0d", tk, ch, level);

      // Load coincident with a press event wins and the event is dropped.
      repeat (20) cyc();
      pb_freq_up = 1'b1;
      repeat (7) cyc();
      lvl_load = 1'b1; lvl_in = 2'd3;
      cyc();
      lvl_load = 1'b0;
      check("load_beats_up", int'(level), 3);
      pb_freq_up = 1'b0;
      repeat (10) cyc();
      check("load_beats_up_after", int'(level), 3);
      load(1);
      pb_freq_up = 1'b1;
      repeat (7) cyc();
      lvl_load = 1'b1; lvl_in = 2'd1;
      cyc();
      lvl_load = 1'b0;
      check("event_discarded", int'(level), 1);
      pb_freq_up = 1'b0;
      repeat (10) cyc();
      lvl_load = 1'b1; lvl_in = 2'd2;
      cyc();
      lvl_load = 1'b0;
      check("load_level2", int'(level), 2);
      t1 = 0; t2 = 0;
      for (int j = 1; j <= 40; j++) begin
         cyc();
         if (tick === 1'b1 && t1 == 0) t1 = j;
         else if (tick === 1'b1 && t2 == 0) t2 = j;
      end
      check("first_tick_lvl2", t1, 9);
      check("tick_period_lvl2", t2 - t1, 16);
      $display("seq load: level=%0d first_tick=%0d period=%0d", level, t1, t2 - t1);

      // Random traffic against the reference model.
      hold_u = 0; hold_d = 0;
      for (int c = 0; c < 3000; c++) begin
         if (hold_u == 0) begin
            pb_freq_up = ($urandom_range(0, 1) == 1);
            hold_u = $urandom_range(1, 14);
         end
         if (hold_d == 0) begin
            pb_freq_dn = ($urandom_range(0, 1) == 1);
            hold_d = $urandom_range(1, 14);
         end
         hold_u--; hold_d--;
         run      = ($urandom_range(0, 15) != 0);
         step     = ($urandom_range(0, 7) == 0);
         lvl_load = ($urandom_range(0, 59) == 0);
         lvl_in   = LW'($urandom_range(0, 3));
         reset    = ($urandom_range(0, 399) != 0);
         cyc();
      end
      $display("seq random: 3000 cycles, errors so far=%0d", errors);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
